// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame: sync marker, command codes,
// FSM state encoding and frame length. Host tooling and the register bank
// reuse the command codes from here.
package uart_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
   localparam logic [7:0] CMD_WRITE     = 8'h01;
   localparam logic [7:0] CMD_READ      = 8'h02;
   localparam int         FRAME_LEN     = 6;     // SYNC CMD ADDR DH DL CHK

   // Encodings are visible on debug_state, keep them stable.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DH    = 3'd3,
      ST_DL    = 3'd4,
      ST_CHK   = 3'd5,
      ST_ISSUE = 3'd6
   } state_t;

   function automatic logic is_cmd_code(input logic [7:0] b);
      return (b == CMD_WRITE) || (b == CMD_READ);
   endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ADDR/DH/DL/CHK frames from the UART byte strobe,
// checks command code and XOR checksum, and hands one decoded command to
// the register-access logic over valid/ready. Includes inter-byte timeout
// recovery and single-cycle error pulses.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CLKS = 50000,
   parameter int         CNT_W        = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic             cmd_rw,
   output logic [7:0]       cmd_addr,
   output logic [15:0]      cmd_wdata,
   output logic             err_chk,
   output logic             err_cmd,
   output logic             err_timeout,
   output logic             err_overrun,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [2:0]       debug_state
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_chk;
   logic             r_rw;
   logic [7:0]       r_addr;
   logic [15:0]      r_wdata;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_err_chk, r_err_cmd, r_err_timeout, r_err_overrun;
   logic             w_err_chk, w_err_cmd, w_err_timeout, w_err_overrun;
   logic             w_counting, w_tmo_hit, w_xfer, w_cmd_valid;

   // Timeout only runs while a frame is partially received; a byte on the
   // terminal-count cycle takes precedence over the timeout.
   assign w_counting = (r_state >= ST_CMD) && (r_state <= ST_CHK);
   assign w_tmo_hit  = w_counting && !rx_valid && (r_tmo_cnt == TMO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: one step per received byte, timeout forces IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) w_state_nxt = ST_CMD;
         ST_CMD:   if (rx_valid) w_state_nxt = is_cmd_code(rx_data) ? ST_ADDR : ST_IDLE;
         ST_ADDR:  if (rx_valid) w_state_nxt = ST_DH;
         ST_DH:    if (rx_valid) w_state_nxt = ST_DL;
         ST_DL:    if (rx_valid) w_state_nxt = ST_CHK;
         ST_CHK:   if (rx_valid) w_state_nxt = (rx_data == r_chk) ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: if (cmd_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (w_tmo_hit) w_state_nxt = ST_IDLE;
   end

   // Outputs: command valid, handshake and error conditions (mutually exclusive)
   always_comb begin
      w_cmd_valid   = (r_state == ST_ISSUE);
      w_xfer        = w_cmd_valid && cmd_ready;
      w_err_cmd     = (r_state == ST_CMD) && rx_valid && !is_cmd_code(rx_data);
      w_err_chk     = (r_state == ST_CHK) && rx_valid && (rx_data != r_chk);
      w_err_overrun = (r_state == ST_ISSUE) && rx_valid;
      w_err_timeout = w_tmo_hit;
   end

   // Frame field capture and running checksum; fields hold through ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk   <= '0;
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (rx_valid) begin
         case (r_state)
            ST_CMD: if (is_cmd_code(rx_data)) begin
               r_rw  <= (rx_data == CMD_WRITE);
               r_chk <= rx_data;
            end
            ST_ADDR: begin r_addr        <= rx_data; r_chk <= r_chk ^ rx_data; end
            ST_DH:   begin r_wdata[15:8] <= rx_data; r_chk <= r_chk ^ rx_data; end
            ST_DL:   begin r_wdata[7:0]  <= rx_data; r_chk <= r_chk ^ rx_data; end
            default: ;
         endcase
      end
   end

   // Inter-byte timer, accepted-command counter and registered error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt     <= '0;
         r_frame_cnt   <= '0;
         r_err_chk     <= 1'b0;
         r_err_cmd     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         if (rx_valid || !w_counting || w_state_nxt == ST_IDLE) r_tmo_cnt <= '0;
         else                                                   r_tmo_cnt <= r_tmo_cnt + 1'b1;
         if (w_xfer) r_frame_cnt <= r_frame_cnt + 1'b1;
         r_err_chk     <= w_err_chk;
         r_err_cmd     <= w_err_cmd;
         r_err_timeout <= w_err_timeout;
         r_err_overrun <= w_err_overrun;
      end
   end

   assign cmd_valid   = w_cmd_valid;
   assign cmd_rw      = r_rw;
   assign cmd_addr    = r_addr;
   assign cmd_wdata   = r_wdata;
   assign err_chk     = r_err_chk;
   assign err_cmd     = r_err_cmd;
   assign err_timeout = r_err_timeout;
   assign err_overrun = r_err_overrun;
   assign frame_cnt   = r_frame_cnt;
   assign debug_state = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus randomized frames
// checked against a frame-level acceptance model.
module tb_uart_cmd_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid, cmd_rw;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        err_chk, err_cmd, err_timeout, err_overrun;
   logic [15:0] frame_cnt;
   logic [2:0]  debug_state;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_cnt  = 0;

   uart_cmd_parser dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .err_chk(err_chk),
      .err_cmd(err_cmd), .err_timeout(err_timeout), .err_overrun(err_overrun),
      .frame_cnt(frame_cnt), .debug_state(debug_state)
   );

   always #5 clk = ~clk;

   // Frame-level model: a frame is accepted iff the command is a known code
   // and the XOR of CMD..DATA_L equals the check byte.
   function automatic bit ref_accept(input logic [7:0] c, a, h, l, k);
      return (c == 8'h01 || c == 8'h02) && ((c ^ a ^ h ^ l) == k);
   endfunction

   // All tasks start and end on a falling edge; one byte per clock.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, a, h, l, k);
      send_byte(8'hAA); send_byte(c); send_byte(a); send_byte(h); send_byte(l); send_byte(k);
   endtask

   task automatic do_handshake;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmd_valid, cmd_rw, cmd_addr, cmd_wdata, err_chk, err_cmd, err_timeout, err_overrun, frame_cnt, debug_state} !== '0)
         $display("FAIL reset_outputs: got valid=%b addr=%h wdata=%h cnt=%0d st=%0d want all zero", cmd_valid, cmd_addr, cmd_wdata, frame_cnt, debug_state);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write;
      cmd_ready = 1'b1;
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
      n_checks++;
      if ({cmd_valid, cmd_rw, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 8'h10, 16'h1234})
         $display("FAIL write_fields: got v=%b rw=%b a=%h d=%h want 1 1 10 1234", cmd_valid, cmd_rw, cmd_addr, cmd_wdata);
      else n_pass++;
      n_checks++;
      if ({err_chk, err_cmd, err_timeout, err_overrun} !== 4'b0)
         $display("FAIL write_noerr: got %b want 0000", {err_chk, err_cmd, err_timeout, err_overrun});
      else n_pass++;
      @(negedge clk);
      cmd_ready = 1'b0;
      exp_cnt++;
      n_checks++;
      if (cmd_valid !== 1'b0 || frame_cnt !== 16'(exp_cnt) || debug_state !== 3'd0)
         $display("FAIL write_done: got v=%b cnt=%0d st=%0d want 0 %0d 0", cmd_valid, frame_cnt, debug_state, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_read_backpressure;
      int bad = 0;
      send_frame(8'h02, 8'h20, 8'h00, 8'h00, 8'h22);
      for (int i = 0; i < 100; i++) begin
         if (cmd_valid !== 1'b1 || cmd_rw !== 1'b0 || cmd_addr !== 8'h20) bad++;
         @(negedge clk);
      end
      n_checks++;
      if (bad != 0) $display("FAIL read_hold: got %0d unstable cycles want 0", bad);
      else n_pass++;
      do_handshake();
      exp_cnt++;
      n_checks++;
      if (cmd_valid !== 1'b0 || frame_cnt !== 16'(exp_cnt))
         $display("FAIL read_done: got v=%b cnt=%0d want 0 %0d", cmd_valid, frame_cnt, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_bad_chk;
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h36);
      n_checks++;
      if (err_chk !== 1'b1 || cmd_valid !== 1'b0)
         $display("FAIL badchk_pulse: got err=%b v=%b want 1 0", err_chk, cmd_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (err_chk !== 1'b0 || debug_state !== 3'd0)
         $display("FAIL badchk_after: got err=%b st=%0d want 0 0", err_chk, debug_state);
      else n_pass++;
      send_frame(8'h01, 8'h44, 8'hAB, 8'hCD, 8'h01 ^ 8'h44 ^ 8'hAB ^ 8'hCD);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_addr !== 8'h44 || cmd_wdata !== 16'hABCD)
         $display("FAIL badchk_recover: got v=%b a=%h d=%h want 1 44 abcd", cmd_valid, cmd_addr, cmd_wdata);
      else n_pass++;
      do_handshake();
      exp_cnt++;
   endtask

   task automatic test_bad_cmd;
      send_byte(8'hAA); send_byte(8'h05);
      n_checks++;
      if (err_cmd !== 1'b1 || debug_state !== 3'd0)
         $display("FAIL badcmd_pulse: got err=%b st=%0d want 1 0", err_cmd, debug_state);
      else n_pass++;
      send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h37);
      n_checks++;
      if ({cmd_valid, err_chk, err_cmd, err_overrun} !== 4'b0 || debug_state !== 3'd0)
         $display("FAIL badcmd_ignore: got v=%b st=%0d want 0 0", cmd_valid, debug_state);
      else n_pass++;
   endtask

   task automatic test_timeout;
      int first = 0, pulses = 0;
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10);
      n_checks++;
      if (debug_state !== 3'd3) $display("FAIL tmo_state: got %0d want 3", debug_state);
      else n_pass++;
      for (int k = 1; k <= 50010; k++) begin
         @(negedge clk);
         if (err_timeout === 1'b1) begin pulses++; if (first == 0) first = k; end
      end
      n_checks++;
      if (first != 50000 || pulses != 1)
         $display("FAIL tmo_pulse: got at cycle %0d (%0d pulses) want 50000 (1)", first, pulses);
      else n_pass++;
      n_checks++;
      if (debug_state !== 3'd0) $display("FAIL tmo_idle: got %0d want 0", debug_state);
      else n_pass++;
      send_frame(8'h02, 8'h5A, 8'h00, 8'h01, 8'h02 ^ 8'h5A ^ 8'h01);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_rw !== 1'b0 || cmd_addr !== 8'h5A)
         $display("FAIL tmo_recover: got v=%b rw=%b a=%h want 1 0 5a", cmd_valid, cmd_rw, cmd_addr);
      else n_pass++;
      do_handshake();
      exp_cnt++;
   endtask

   task automatic test_overrun;
      send_frame(8'h01, 8'h33, 8'hBE, 8'hEF, 8'h01 ^ 8'h33 ^ 8'hBE ^ 8'hEF);
      send_byte(8'h55);
      n_checks++;
      if (err_overrun !== 1'b1 || cmd_valid !== 1'b1 || cmd_addr !== 8'h33 || cmd_wdata !== 16'hBEEF)
         $display("FAIL overrun_pulse: got err=%b v=%b a=%h d=%h want 1 1 33 beef", err_overrun, cmd_valid, cmd_addr, cmd_wdata);
      else n_pass++;
      @(negedge clk);
      send_byte(8'hAA);
      n_checks++;
      if (err_overrun !== 1'b1 || debug_state !== 3'd6 || cmd_rw !== 1'b1)
         $display("FAIL overrun_sync: got err=%b st=%0d rw=%b want 1 6 1", err_overrun, debug_state, cmd_rw);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (err_overrun !== 1'b0) $display("FAIL overrun_width: got %b want 0", err_overrun);
      else n_pass++;
      do_handshake();
      exp_cnt++;
      n_checks++;
      if (frame_cnt !== 16'(exp_cnt) || debug_state !== 3'd0)
         $display("FAIL overrun_done: got cnt=%0d st=%0d want %0d 0", frame_cnt, debug_state, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_random;
      for (int it = 0; it < 30; it++) begin
         logic [7:0] c, a, h, l, k, j;
         int kind;
         bit cmd_ok, ok;
         kind = $urandom_range(0, 3);
         c = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02;
         a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
         k = c ^ a ^ h ^ l;
         if (kind == 2) k = k ^ 8'($urandom_range(1, 255));
         if (kind == 3) begin c = 8'($urandom); if (c == 8'h01 || c == 8'h02) c = 8'hFE; end
         repeat ($urandom_range(0, 2)) begin
            j = 8'($urandom); if (j == 8'hAA) j = 8'h00;
            send_byte(j);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         cmd_ok = (c == 8'h01 || c == 8'h02);
         ok = ref_accept(c, a, h, l, k);
         if (!cmd_ok) begin
            send_byte(8'hAA); send_byte(c);
            n_checks++;
            if (err_cmd !== 1'b1) $display("FAIL rnd%0d_cmd: got err_cmd=%b want 1 (c=%h)", it, err_cmd, c);
            else n_pass++;
         end else begin
            send_frame(c, a, h, l, k);
            if (ok) begin
               n_checks++;
               if (cmd_valid !== 1'b1 || cmd_rw !== (c == 8'h01) || cmd_addr !== a || cmd_wdata !== {h, l})
                  $display("FAIL rnd%0d_fields: got v=%b rw=%b a=%h d=%h want 1 %b %h %h%h", it, cmd_valid, cmd_rw, cmd_addr, cmd_wdata, c == 8'h01, a, h, l);
               else n_pass++;
               repeat ($urandom_range(0, 5)) @(negedge clk);
               do_handshake();
               exp_cnt++;
               n_checks++;
               if (cmd_valid !== 1'b0 || frame_cnt !== 16'(exp_cnt))
                  $display("FAIL rnd%0d_cnt: got v=%b cnt=%0d want 0 %0d", it, cmd_valid, frame_cnt, exp_cnt);
               else n_pass++;
            end else begin
               n_checks++;
               if (err_chk !== 1'b1 || cmd_valid !== 1'b0)
                  $display("FAIL rnd%0d_chk: got err=%b v=%b want 1 0", it, err_chk, cmd_valid);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      send_byte(8'hAA); send_byte(8'h01);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cmd_valid, cmd_rw, cmd_addr, cmd_wdata, err_chk, err_cmd, err_timeout, err_overrun, frame_cnt, debug_state} !== '0)
         $display("FAIL rst_mid: got v=%b cnt=%0d st=%0d want all zero", cmd_valid, frame_cnt, debug_state);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
      do_handshake();
      exp_cnt++;
      n_checks++;
      if (frame_cnt !== 16'(exp_cnt) || cmd_valid !== 1'b0)
         $display("FAIL rst_after: got cnt=%0d v=%b want 1 0", frame_cnt, cmd_valid);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_backpressure();
      test_bad_chk();
      test_bad_cmd();
      test_timeout();
      test_overrun();
      test_random();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
